// File: rtl/sha_host_sequencer.sv
// Host-side initiator for the SHA-256 core: loads a byte stream into the message SRAM,
// pulses go with the length, waits for finish, then streams the digest words back out.
module sha_host_sequencer #(
    parameter int unsigned MAX_MESSAGE_LENGTH = 55,
    parameter int unsigned OUTPUT_LENGTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    localparam int unsigned LW = $clog2(MAX_MESSAGE_LENGTH),
    localparam int unsigned OW = $clog2(OUTPUT_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic [LW-1:0] host__msg__address,
    output logic          host__msg__enable,
    output logic          host__msg__write,
    output logic [7:0]    host__msg__data,
    output logic          xxx__dut__go,
    output logic [LW:0]   xxx__dut__msg_length,
    input  logic          dut__xxx__finish,
    output logic [OW-1:0] host__dom__address,
    output logic          host__dom__enable,
    output logic          host__dom__write,
    input  logic [31:0]   dom__host__data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err_overflow,
    output logic          err_timeout
);
    localparam int unsigned CW = LW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_GO     = 3'd2,
        S_WAIT   = 3'd3,
        S_RD_REQ = 3'd4,
        S_RD_CAP = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_count;
    logic [TW-1:0] r_wdog;
    logic [OW-1:0] r_widx;

    logic          r_go;
    logic [CW-1:0] r_msg_length;
    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic          r_out_last;
    logic          r_err_overflow;
    logic          r_err_timeout;

    logic          w_in_ready;
    logic          w_accept;
    logic [CW-1:0] w_count_inc;
    logic          w_full;
    logic          w_end_msg;
    logic          w_finish;
    logic          w_timeout;
    logic          w_last_word;
    logic          w_handshake;

    assign w_accept    = in_valid && w_in_ready;
    assign w_count_inc = r_count + CW'(1);
    assign w_full      = (w_count_inc == CW'(MAX_MESSAGE_LENGTH));
    // A message ends on its last byte, or when it fills the SRAM without one
    assign w_end_msg   = w_accept && (in_last || w_full);
    assign w_finish    = (r_state == S_WAIT) && dut__xxx__finish;
    assign w_timeout   = (r_state == S_WAIT) && !dut__xxx__finish
                         && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
    assign w_last_word = (r_widx == OW'(OUTPUT_LENGTH - 1));
    assign w_handshake = (r_state == S_HOLD) && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_end_msg) begin
                    w_state_nxt = S_GO;
                end else if (w_accept) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_GO: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_finish) begin
                    w_state_nxt = S_RD_REQ;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = w_last_word ? S_IDLE : S_RD_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded combinational outputs
    always_comb begin
        w_in_ready         = 1'b0;
        busy               = 1'b1;
        host__dom__enable  = 1'b0;
        host__dom__address = '0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                busy       = 1'b0;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
            end
            S_RD_REQ: begin
                host__dom__enable  = 1'b1;
                host__dom__address = r_widx;
            end
            default: begin
            end
        endcase
    end

    // Counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= '0;
            r_wdog         <= '0;
            r_widx         <= '0;
            r_go           <= 1'b0;
            r_msg_length   <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_last     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (w_end_msg) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= w_count_inc;
            end

            // Length stays put after go; the core compares against it while hashing
            r_go <= w_end_msg;
            if (w_end_msg) begin
                r_msg_length <= w_count_inc;
            end

            if (r_state == S_GO) begin
                r_wdog <= '0;
            end else if ((r_state == S_WAIT) && !dut__xxx__finish
                         && (r_wdog != TW'(TIMEOUT_CYCLES))) begin
                r_wdog <= r_wdog + TW'(1);
            end

            if (w_accept && w_full && !in_last) begin
                r_err_overflow <= 1'b1;
            end else if (w_accept && (r_state == S_IDLE)) begin
                r_err_overflow <= 1'b0;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (w_accept && (r_state == S_IDLE)) begin
                r_err_timeout <= 1'b0;
            end

            if (w_finish) begin
                r_widx <= '0;
            end else if (w_handshake && !w_last_word) begin
                r_widx <= r_widx + OW'(1);
            end

            if (r_state == S_RD_CAP) begin
                r_out_valid <= 1'b1;
                r_out_data  <= dom__host__data;
                r_out_last  <= w_last_word;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign in_ready             = w_in_ready;
    assign host__msg__enable    = w_accept;
    assign host__msg__write     = w_accept;
    assign host__msg__address   = r_count[LW-1:0];
    assign host__msg__data      = in_data;
    assign host__dom__write     = 1'b0;
    assign xxx__dut__go         = r_go;
    assign xxx__dut__msg_length = r_msg_length;
    assign out_valid            = r_out_valid;
    assign out_data             = r_out_data;
    assign out_last             = r_out_last;
    assign err_overflow         = r_err_overflow;
    assign err_timeout          = r_err_timeout;

endmodule

// File: tb/tb_sha_host_sequencer.sv
// Randomized bench for sha_host_sequencer: models the message SRAM, the digest memory
// and the core's finish pulse, and checks each message against its expected transaction.
module tb_sha_host_sequencer;
    localparam int MAXL = 55;
    localparam int OLEN = 8;
    localparam int TMO  = 255;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic [5:0]  host__msg__address;
    logic        host__msg__enable;
    logic        host__msg__write;
    logic [7:0]  host__msg__data;
    logic        xxx__dut__go;
    logic [6:0]  xxx__dut__msg_length;
    logic        dut__xxx__finish = 1'b0;
    logic [2:0]  host__dom__address;
    logic        host__dom__enable;
    logic        host__dom__write;
    logic [31:0] dom_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_overflow;
    logic        err_timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [2:0]  rd_addr_q [$];
    logic [31:0] out_q [$];
    logic        last_q [$];
    int          go_cycles;
    int          valid_cycles;
    logic [31:0] dom_mem [OLEN];

    sha_host_sequencer #(
        .MAX_MESSAGE_LENGTH(MAXL),
        .OUTPUT_LENGTH(OLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .host__msg__address(host__msg__address),
        .host__msg__enable(host__msg__enable),
        .host__msg__write(host__msg__write),
        .host__msg__data(host__msg__data),
        .xxx__dut__go(xxx__dut__go),
        .xxx__dut__msg_length(xxx__dut__msg_length),
        .dut__xxx__finish(dut__xxx__finish),
        .host__dom__address(host__dom__address),
        .host__dom__enable(host__dom__enable),
        .host__dom__write(host__dom__write),
        .dom__host__data(dom_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Digest memory: synchronous read, data one cycle after enable
    always @(posedge clk) begin
        if (host__dom__enable) dom_rdata <= dom_mem[host__dom__address];
    end

    // Transaction logger, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (host__msg__enable && host__msg__write) begin
                wr_addr_q.push_back(host__msg__address);
                wr_data_q.push_back(host__msg__data);
            end
            if (xxx__dut__go) go_cycles++;
            if (host__dom__enable) rd_addr_q.push_back(host__dom__address);
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        out_q.delete();
        last_q.delete();
        go_cycles    = 0;
        valid_cycles = 0;
        for (int i = 0; i < OLEN; i++) dom_mem[i] = $urandom;
    endtask

    function automatic byte_q_t make_msg(int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Drives bytes with random gaps; returns in the cycle after the final acceptance
    task automatic send_bytes(input byte_q_t msg, input bit with_last);
        for (int i = 0; i < msg.size(); i++) begin
            int guard;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = with_last && (i == msg.size() - 1);
            guard = 0;
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL in_ready_byte%0d: got %b want 1", i, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called in the go cycle; leaves the bench in the first WAIT cycle
    task automatic check_go(input int exp_len);
        n_vec++;
        if (xxx__dut__go !== 1'b1 || xxx__dut__msg_length !== 7'(exp_len)) begin
            n_err++;
            $display("FAIL go_pulse: go=%b len=%0d want go=1 len=%0d", xxx__dut__go, xxx__dut__msg_length, exp_len);
        end
        step();
        n_vec++;
        if (xxx__dut__go !== 1'b0 || xxx__dut__msg_length !== 7'(exp_len) || go_cycles != 1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL go_one_cycle: go=%b len=%0d go_cycles=%0d busy=%b want 0/%0d/1/1", xxx__dut__go, xxx__dut__msg_length, go_cycles, busy, exp_len);
        end
    endtask

    task automatic check_writes(input byte_q_t msg, input int n);
        n_vec++;
        if (wr_addr_q.size() != n) begin
            n_err++;
            $display("FAIL write_count: got %0d want %0d", wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            n_vec++;
            if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== msg[i]) begin
                n_err++;
                $display("FAIL write%0d: addr=%0d data=%h want addr=%0d data=%h", i, wr_addr_q[i], wr_data_q[i], i, msg[i]);
            end
        end
    endtask

    // Called in a WAIT cycle; pulses finish after delay cycles, checks read latency
    task automatic fire_finish(input int delay);
        out_ready = 1'b0;
        repeat (delay) step();
        dut__xxx__finish = 1'b1;
        step();
        dut__xxx__finish = 1'b0;
        n_vec++;
        if (host__dom__enable !== 1'b1 || host__dom__address !== 3'd0) begin
            n_err++;
            $display("FAIL first_read: en=%b addr=%0d want en=1 addr=0", host__dom__enable, host__dom__address);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0 || host__dom__enable !== 1'b0) begin
            n_err++;
            $display("FAIL rd_cap_cycle: valid=%b en=%b want 0/0", out_valid, host__dom__enable);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== dom_mem[0]) begin
            n_err++;
            $display("FAIL first_word: valid=%b data=%h want 1/%h", out_valid, out_data, dom_mem[0]);
        end
    endtask

    task automatic collect_and_check(input int ready_pct);
        for (int c = 0; c < 400 && out_q.size() < OLEN; c++) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            step();
        end
        out_ready = 1'b0;
        n_vec++;
        if (out_q.size() != OLEN) begin
            n_err++;
            $display("FAIL word_count: got %0d want %0d", out_q.size(), OLEN);
        end
        for (int i = 0; i < out_q.size() && i < OLEN; i++) begin
            n_vec++;
            if (out_q[i] !== dom_mem[i] || last_q[i] !== (i == OLEN - 1)) begin
                n_err++;
                $display("FAIL word%0d: data=%h last=%b want %h/%b", i, out_q[i], last_q[i], dom_mem[i], (i == OLEN - 1));
            end
        end
        n_vec++;
        if (rd_addr_q.size() != OLEN) begin
            n_err++;
            $display("FAIL read_count: got %0d want %0d", rd_addr_q.size(), OLEN);
        end
        for (int i = 0; i < rd_addr_q.size() && i < OLEN; i++) begin
            n_vec++;
            if (rd_addr_q[i] !== 3'(i)) begin
                n_err++;
                $display("FAIL read%0d: addr=%0d want %0d", i, rd_addr_q[i], i);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || go_cycles != 1) begin
            n_err++;
            $display("FAIL end_of_message: busy=%b valid=%b go_cycles=%0d want 0/0/1", busy, out_valid, go_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if (xxx__dut__go !== 1'b0 || xxx__dut__msg_length !== 7'd0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: go=%b len=%0d valid=%b data=%h last=%b want all 0", xxx__dut__go, xxx__dut__msg_length, out_valid, out_data, out_last);
        end
        n_vec++;
        if (err_overflow !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || host__dom__enable !== 1'b0 || host__dom__write !== 1'b0 || host__msg__enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ov=%b to=%b busy=%b rdy=%b den=%b dwr=%b men=%b want 0 0 0 1 0 0 0", err_overflow, err_timeout, busy, in_ready, host__dom__enable, host__dom__write, host__msg__enable);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        byte_q_t msg;
        msg = {8'h61, 8'h62, 8'h63};
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(3);
        check_writes(msg, 3);
        fire_finish(2);
        collect_and_check(100);
        n_vec++;
        if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL basic_flags: ov=%b to=%b want 0/0", err_overflow, err_timeout);
        end
    endtask

    task automatic test_overflow();
        byte_q_t msg;
        byte_q_t head;
        byte_q_t tail;
        msg = make_msg(60);
        for (int i = 0; i < 60; i++) begin
            if (i < MAXL) head.push_back(msg[i]);
            else tail.push_back(msg[i]);
        end
        clear_logs();
        send_bytes(head, 1'b0);
        n_vec++;
        if (err_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flag: got %b want 1", err_overflow);
        end
        check_go(MAXL);
        check_writes(msg, MAXL);
        in_valid = 1'b1;
        in_data  = tail[0];
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL overflow_in_ready%0d: got %b want 0", k, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        fire_finish(0);
        collect_and_check(80);
        n_vec++;
        if (err_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: got %b want 1", err_overflow);
        end
        clear_logs();
        send_bytes(tail, 1'b1);
        n_vec++;
        if (err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got %b want 0", err_overflow);
        end
        check_go(5);
        check_writes(tail, 5);
        fire_finish(1);
        collect_and_check(100);
    endtask

    task automatic test_backpressure();
        byte_q_t msg;
        int guard;
        msg = make_msg(7);
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(7);
        fire_finish(4);
        guard = 0;
        while (!(out_q.size() == 2 && out_valid) && guard < 100) begin
            out_ready = 1'b1;
            step();
            guard++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== dom_mem[2] || out_last !== 1'b0 || host__dom__enable !== 1'b0) begin
                n_err++;
                $display("FAIL hold%0d: valid=%b data=%h last=%b den=%b want 1/%h/0/0", k, out_valid, out_data, out_last, host__dom__enable, dom_mem[2]);
            end
            step();
        end
        collect_and_check(100);
    endtask

    task automatic test_timeout();
        byte_q_t msg;
        msg = make_msg(4);
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(4);
        repeat (TMO - 1) step();
        n_vec++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: to=%b busy=%b want 0/1", err_timeout, busy);
        end
        step();
        n_vec++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || valid_cycles != 0 || rd_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_fire: to=%b busy=%b valid_cycles=%0d reads=%0d want 1/0/0/0", err_timeout, busy, valid_cycles, rd_addr_q.size());
        end
        msg = make_msg(2);
        clear_logs();
        send_bytes(msg, 1'b1);
        n_vec++;
        if (err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: got %b want 0", err_timeout);
        end
        check_go(2);
        fire_finish(0);
        collect_and_check(60);
    endtask

    task automatic test_spurious_finish();
        byte_q_t msg;
        byte_q_t head;
        byte_q_t tail;
        msg = make_msg(5);
        for (int i = 0; i < 5; i++) begin
            if (i < 2) head.push_back(msg[i]);
            else tail.push_back(msg[i]);
        end
        clear_logs();
        send_bytes(head, 1'b0);
        dut__xxx__finish = 1'b1;
        step();
        dut__xxx__finish = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || host__dom__enable !== 1'b0 || xxx__dut__go !== 1'b0) begin
            n_err++;
            $display("FAIL finish_in_load: busy=%b rdy=%b den=%b go=%b want 1/1/0/0", busy, in_ready, host__dom__enable, xxx__dut__go);
        end
        send_bytes(tail, 1'b1);
        check_go(5);
        check_writes(msg, 5);
        fire_finish(1);
        dut__xxx__finish = 1'b1;
        step();
        dut__xxx__finish = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== dom_mem[0] || host__dom__enable !== 1'b0) begin
            n_err++;
            $display("FAIL finish_in_hold: valid=%b data=%h den=%b want 1/%h/0", out_valid, out_data, host__dom__enable, dom_mem[0]);
        end
        collect_and_check(70);
    endtask

    task automatic test_reset_mid();
        byte_q_t msg;
        msg = make_msg(3);
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(3);
        step();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (xxx__dut__go !== 1'b0 || xxx__dut__msg_length !== 7'd0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0 || err_overflow !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0 || host__dom__enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_wait: go=%b len=%0d valid=%b data=%h last=%b busy=%b want all 0", xxx__dut__go, xxx__dut__msg_length, out_valid, out_data, out_last, busy);
        end
        step();
        reset = 1'b1;
        msg = make_msg(1);
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(1);
        check_writes(msg, 1);
        fire_finish(3);
        collect_and_check(100);

        msg = make_msg(2);
        clear_logs();
        send_bytes(msg, 1'b1);
        check_go(2);
        fire_finish(0);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_hold: valid=%b data=%h busy=%b want 0/0/0", out_valid, out_data, busy);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_random_messages();
        for (int m = 0; m < 6; m++) begin
            byte_q_t msg;
            int n;
            n = (m == 0) ? MAXL : (m == 1) ? 1 : $urandom_range(1, MAXL);
            msg = make_msg(n);
            clear_logs();
            send_bytes(msg, 1'b1);
            check_go(n);
            check_writes(msg, n);
            fire_finish((m == 2) ? 0 : $urandom_range(0, 20));
            collect_and_check($urandom_range(30, 100));
            n_vec++;
            if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL random%0d_flags: ov=%b to=%b want 0/0", m, err_overflow, err_timeout);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_spurious_finish();
        test_reset_mid();
        test_random_messages();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
